or1200_cust5_sha3_if: RTL

Command-side responder for the l.cust5 SHA3-512 instructions issued by the OR1200 execute stage. Decodes the HEAD / DATA / TAIL / STORE sub-operations, packs 32-bit message words into 576-bit rate blocks, applies SHA3 padding, and hands blocks to the Keccak core over a valid/ready handshake. It captures the 512-bit digest returned by the core and serves it back to the ALU result path one 32-bit word at a time. Sits between the or1200 ALU cust5 port and the Keccak permutation core.

---
 rtl/or1200_cust5_sha3_if.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/or1200_cust5_sha3_if.sv
// ---------------------------------------------------------------------------
// or1200_cust5_sha3_if
//
// Command-side responder for the l.cust5 SHA3-512 instructions.
// HEAD starts a message. DATA packs 32-bit words into a 576-bit rate block.
// TAIL applies SHA3 padding (0x06 ... 0x80) and closes the message. STORE
// reads one 32-bit word of the captured digest back to the ALU result path.
// Full and final blocks go to the Keccak core over a valid/ready handshake.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-low reset
//   ex_freeze           execute-stage freeze; blocks command acceptance
//   alu_op, cust5_op    opcode / sub-op (HEAD 00100, DATA 00010,
//                       TAIL 00001, STORE 01000)
//   cust5_limm          STORE word select (limm[5:4] must be 0)
//   operand_a           message word, first character in [31:24]
//   result              STORE read data (0 when not a STORE)
//   busy                stall request while a block is awaiting the core
//   blk_data/valid/last block to the core, word i at [575-32i -: 32]
//   blk_ready           core accepts block
//   dig_in, dig_valid   512-bit digest and its one-cycle strobe
//
// Optional feature: define OR1200_SHA3_STATUS_EN to add the STATUS sub-op
// (10000), which returns {23'b0, done, busy_state, count, idle, 1'b0}.
// ---------------------------------------------------------------------------
module or1200_cust5_sha3_if #(
  parameter int RATE_WORDS = 18
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_freeze,
  input  logic [4:0]                alu_op,
  input  logic [4:0]                cust5_op,
  input  logic [5:0]                cust5_limm,
  input  logic [31:0]               operand_a,
  output logic [31:0]               result,
  output logic                      busy,
  output logic [32*RATE_WORDS-1:0]  blk_data,
  output logic                      blk_valid,
  output logic                      blk_last,
  input  logic                      blk_ready,
  input  logic [511:0]              dig_in,
  input  logic                      dig_valid
);

  localparam int          CW        = $clog2(RATE_WORDS + 1);
  localparam logic [4:0]  ALU_CUST5 = 5'b1_0010;
  localparam logic [4:0]  OP_TAIL   = 5'b0_0001;
  localparam logic [4:0]  OP_DATA   = 5'b0_0010;
  localparam logic [4:0]  OP_HEAD   = 5'b0_0100;
  localparam logic [4:0]  OP_STORE  = 5'b0_1000;
  localparam logic [31:0] PAD_FIRST = 32'h0600_0000;
  localparam logic [31:0] PAD_LAST  = 32'h0000_0080;
`ifdef OR1200_SHA3_STATUS_EN
  localparam logic [4:0]  OP_STATUS = 5'b1_0000;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_SEND, S_SENDLAST, S_WAIT_DIG
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   buf_q [RATE_WORDS];
  logic [31:0]   buf_d [RATE_WORDS];
  logic [511:0]  digest_q, digest_d;
`ifdef OR1200_SHA3_STATUS_EN
  logic          done_q, done_d;
`endif

  logic       cust5_cmd;
  logic       sending;
  logic       op_defined;
  logic       acc;
  logic [8:0] store_lsb;

  assign cust5_cmd = (alu_op == ALU_CUST5) && !ex_freeze;
  assign sending   = (state_q == S_SEND) || (state_q == S_SENDLAST);

  // DATA/TAIL cannot touch the buffer while a block is held for the core,
  // so they stall; HEAD (abort) and STORE are always serviced at once.
  assign busy = cust5_cmd && sending &&
                ((cust5_op == OP_DATA) || (cust5_op == OP_TAIL));

`ifdef OR1200_SHA3_STATUS_EN
  assign op_defined = (cust5_op == OP_HEAD) || (cust5_op == OP_DATA) ||
                      (cust5_op == OP_TAIL) || (cust5_op == OP_STORE) ||
                      (cust5_op == OP_STATUS);
`else
  assign op_defined = (cust5_op == OP_HEAD) || (cust5_op == OP_DATA) ||
                      (cust5_op == OP_TAIL) || (cust5_op == OP_STORE);
`endif

  assign acc       = cust5_cmd && !busy && op_defined;
  assign store_lsb = {cust5_limm[3:0], 5'b0_0000};

  assign blk_valid = sending;
  assign blk_last  = (state_q == S_SENDLAST);

  for (genvar i = 0; i < RATE_WORDS; i++) begin : g_pack
    assign blk_data[32*(RATE_WORDS-1-i) +: 32] = buf_q[i];
  end

  // Zero-latency read path for STORE (and STATUS when enabled).
  always_comb begin
    result = '0;
    if (acc && (cust5_op == OP_STORE) && (cust5_limm[5:4] == 2'b00)) begin
      result = digest_q[store_lsb +: 32];
    end
`ifdef OR1200_SHA3_STATUS_EN
    if (acc && (cust5_op == OP_STATUS)) begin
      result = {23'b0, done_q, (sending || (state_q == S_WAIT_DIG)),
                5'(count_q), (state_q == S_IDLE), 1'b0};
    end
`endif
  end

  always_comb begin
    // NOTE: every next-state signal gets a hold value first so no path through
    // the case/if tree leaves one unassigned and infers a latch.
    state_d  = state_q;
    count_d  = count_q;
    buf_d    = buf_q;
    digest_d = digest_q;
`ifdef OR1200_SHA3_STATUS_EN
    done_d   = done_q;
`endif

    // Handshake / digest progress; an accepted HEAD below overrides all of it.
    case (state_q)
      S_SEND: begin
        if (blk_ready) begin
          state_d = S_FILL;
          count_d = '0;
          for (int i = 0; i < RATE_WORDS; i++) buf_d[i] = '0;
        end
      end
      S_SENDLAST: begin
        if (blk_ready) state_d = S_WAIT_DIG;
      end
      S_WAIT_DIG: begin
        if (dig_valid) begin
          digest_d = dig_in;
          state_d  = S_IDLE;
`ifdef OR1200_SHA3_STATUS_EN
          done_d   = 1'b1;
`endif
        end
      end
      default: ;
    endcase

    if (acc) begin
      case (cust5_op)
        OP_HEAD: begin
          for (int i = 0; i < RATE_WORDS; i++) buf_d[i] = '0;
          buf_d[0] = operand_a;
          count_d  = CW'(1);
          state_d  = S_FILL;
          digest_d = digest_q;  // a same-cycle dig_valid is dropped
`ifdef OR1200_SHA3_STATUS_EN
          done_d   = 1'b0;
`endif
        end
        OP_DATA: begin
          if (state_q == S_FILL) begin
            for (int i = 0; i < RATE_WORDS; i++) begin
              if (count_q == CW'(i)) buf_d[i] = operand_a;
            end
            count_d = count_q + CW'(1);
            if (count_q == CW'(RATE_WORDS - 1)) state_d = S_SEND;
          end
        end
        OP_TAIL: begin
          if (state_q == S_FILL) begin
            for (int i = 0; i < RATE_WORDS; i++) begin
              if (count_q == CW'(i)) buf_d[i] = buf_q[i] | PAD_FIRST;
            end
            // Applied on top of buf_d so both pad bytes merge when count=17.
            buf_d[RATE_WORDS-1] = buf_d[RATE_WORDS-1] | PAD_LAST;
            state_d = S_SENDLAST;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      // NOTE: the block buffer is reset (not left as plain storage) because
      // it drives blk_data directly and must read as zero out of reset.
      for (int i = 0; i < RATE_WORDS; i++) buf_q[i] <= '0;
      digest_q <= '0;
`ifdef OR1200_SHA3_STATUS_EN
      done_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      for (int i = 0; i < RATE_WORDS; i++) buf_q[i] <= buf_d[i];
      digest_q <= digest_d;
`ifdef OR1200_SHA3_STATUS_EN
      done_q   <= done_d;
`endif
    end
  end

endmodule
